// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer slice.
package bist_pkg;

  localparam int unsigned BIST_RUN_CYCLES = 18;
  localparam int unsigned BIST_LAST_DUR   = 17;
  localparam int unsigned BIST_NUM_PAT    = 2;

  typedef enum logic [2:0] {IDLE, SELECT, START, RUN, DONE} bist_seq_state_e;

  typedef enum logic {REQ_POR, REQ_JTAG} bist_req_e;

  // An empty JTAG mask means "run everything".
  function automatic logic [1:0] norm_mask(input logic [1:0] m);
    return (m == '0) ? '1 : m;
  endfunction

  function automatic logic lowest_pat(input logic [1:0] rem);
    return !rem[0] && rem[1];
  endfunction

endpackage

// File: rtl/bist_req_arb.sv
// Request capture for the BIST sequencer: one-deep POR/JTAG pending flags,
// JTAG mask latch and POR-first grant.
module bist_req_arb
  import bist_pkg::*;
(
  input  logic       clk,
  input  logic       trst,
  input  logic       por_req_i,
  input  logic       jtag_req_i,
  input  logic [1:0] jtag_mask_i,
  input  logic       grant_en,
  output logic       grant_o,
  output bist_req_e  grant_req_o,
  output logic [1:0] grant_mask_o
);

  logic       por_pend;
  logic       jtag_pend;
  logic [1:0] jtag_mask;

  assign grant_o      = grant_en && (por_pend || jtag_pend);
  assign grant_req_o  = por_pend ? REQ_POR : REQ_JTAG;
  assign grant_mask_o = por_pend ? 2'b11 : norm_mask(jtag_mask);

  // A request in the same cycle its flag is consumed re-pends it.
  always_ff @(posedge clk) begin
    if (trst) begin
      por_pend  <= 1'b0;
      jtag_pend <= 1'b0;
      jtag_mask <= '0;
    end else begin
      por_pend  <= por_req_i  || (por_pend  && !(grant_o && grant_req_o == REQ_POR));
      jtag_pend <= jtag_req_i || (jtag_pend && !(grant_o && grant_req_o == REQ_JTAG));
      if (jtag_req_i) jtag_mask <= jtag_mask_i;
    end
  end

endmodule

// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: grants POR/JTAG run requests and steps the engine through its patterns.
// Define BIST_SEQ_RETRY_EN to rerun a failed pattern once before recording its result.
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned NUM_PAT    = BIST_NUM_PAT,
  parameter int unsigned RUN_CYCLES = BIST_RUN_CYCLES,
  parameter int unsigned LAST_DUR   = BIST_LAST_DUR
) (
  input  logic       clk,
  input  logic       trst,
  input  logic       por_req_i,
  input  logic       jtag_req_i,
  input  logic [1:0] jtag_mask_i,
  input  logic       abort_i,
  input  logic       bist_success_i,
  input  logic [4:0] bist_duration_i,
  output logic       bist_start_o,
  output logic       bist_pat_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       owner_o,
  output logic [1:0] result_o,
  output logic       pass_o,
  output logic       dur_err_o
);

  bist_seq_state_e    state_q, state_d;
  logic               pat_q, pat_d;
  logic [4:0]         wait_q, wait_d;
  logic [NUM_PAT-1:0] mask_q, mask_d, ran_q, ran_d, res_q, res_d, rem;
  logic               pass_q, pass_d, derr_q, derr_d;
  bist_req_e          owner_q, owner_d;
  logic               start, done, dur_ok, retry;
  logic               grant;
  bist_req_e          grant_req;
  logic [1:0]         grant_mask;
`ifdef BIST_SEQ_RETRY_EN
  logic [NUM_PAT-1:0] retried_q, retried_d;
`endif

  bist_req_arb u_arb (
    .clk          (clk),
    .trst         (trst),
    .por_req_i    (por_req_i),
    .jtag_req_i   (jtag_req_i),
    .jtag_mask_i  (jtag_mask_i),
    .grant_en     (state_q == IDLE),
    .grant_o      (grant),
    .grant_req_o  (grant_req),
    .grant_mask_o (grant_mask)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    wait_d  = wait_q;
    mask_d  = mask_q;
    ran_d   = ran_q;
    res_d   = res_q;
    pass_d  = pass_q;
    derr_d  = derr_q;
    owner_d = owner_q;
`ifdef BIST_SEQ_RETRY_EN
    retried_d = retried_q;
    retry     = !bist_success_i && (bist_duration_i == 5'(LAST_DUR)) && !retried_q[pat_q];
`else
    retry     = 1'b0;
`endif
    start  = 1'b0;
    done   = 1'b0;
    rem    = '0;
    dur_ok = (bist_duration_i == 5'(LAST_DUR));

    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          owner_d = grant_req;
          mask_d  = grant_mask;
          ran_d   = '0;
          res_d   = '0;
          pass_d  = 1'b0;
`ifdef BIST_SEQ_RETRY_EN
          retried_d = '0;
`endif
          state_d = SELECT;
        end
        SELECT: begin
          rem = mask_q & ~ran_q;
          if (|rem) begin
            pat_d   = lowest_pat(rem);
            state_d = START;
          end else begin
            pass_d  = (res_q & mask_q) == mask_q;
            state_d = DONE;
          end
        end
        START: begin
          start   = 1'b1;
          wait_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          wait_d = wait_q + 5'd1;
          if (wait_q == 5'(RUN_CYCLES)) begin
            if (!dur_ok) derr_d = 1'b1;
            if (retry) begin
`ifdef BIST_SEQ_RETRY_EN
              retried_d[pat_q] = 1'b1;
`endif
              state_d = START;
            end else begin
              res_d[pat_q] = bist_success_i && dur_ok;
              ran_d[pat_q] = 1'b1;
              // Selection folded into the sample cycle so patterns start 20 cycles apart.
              rem = mask_q & ~ran_d;
              if (|rem) begin
                pat_d   = lowest_pat(rem);
                state_d = START;
              end else begin
                pass_d  = (res_d & mask_q) == mask_q;
                state_d = DONE;
              end
            end
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (trst) begin
      state_q <= IDLE;
      pat_q   <= 1'b0;
      wait_q  <= '0;
      mask_q  <= '0;
      ran_q   <= '0;
      res_q   <= '0;
      pass_q  <= 1'b0;
      derr_q  <= 1'b0;
      owner_q <= REQ_POR;
`ifdef BIST_SEQ_RETRY_EN
      retried_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      wait_q  <= wait_d;
      mask_q  <= mask_d;
      ran_q   <= ran_d;
      res_q   <= res_d;
      pass_q  <= pass_d;
      derr_q  <= derr_d;
      owner_q <= owner_d;
`ifdef BIST_SEQ_RETRY_EN
      retried_q <= retried_d;
`endif
    end
  end

  assign bist_start_o = start;
  assign done_o       = done;
  assign bist_pat_o   = pat_q;
  assign busy_o       = (state_q != IDLE);
  assign owner_o      = (owner_q == REQ_JTAG);
  assign result_o     = res_q;
  assign pass_o       = pass_q;
  assign dur_err_o    = derr_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Self-checking bench for bist_seq_ctrl: stub engine, timeline model and directed scenarios.
module tb_bist_seq_ctrl;

  logic       clk = 1'b0;
  logic       trst, por_req_i, jtag_req_i, abort_i, bist_success_i;
  logic [1:0] jtag_mask_i;
  logic [4:0] bist_duration_i;
  logic       bist_start_o, bist_pat_o, busy_o, done_o, owner_o, pass_o, dur_err_o;
  logic [1:0] result_o;

  always #5 clk = ~clk;

  bist_seq_ctrl dut (
    .clk             (clk),
    .trst            (trst),
    .por_req_i       (por_req_i),
    .jtag_req_i      (jtag_req_i),
    .jtag_mask_i     (jtag_mask_i),
    .abort_i         (abort_i),
    .bist_success_i  (bist_success_i),
    .bist_duration_i (bist_duration_i),
    .bist_start_o    (bist_start_o),
    .bist_pat_o      (bist_pat_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .owner_o         (owner_o),
    .result_o        (result_o),
    .pass_o          (pass_o),
    .dur_err_o       (dur_err_o)
  );

  // Stub engine: duration counts from the start pulse and saturates at dur_max.
  logic [1:0]  good, fail_first;
  logic [4:0]  dur_max;
  logic        stub_act, stub_pat;
  logic [4:0]  stub_cnt;
  int unsigned attempts [2];

  always @(posedge clk) begin
    if (trst) begin
      stub_act    <= 1'b0;
      stub_cnt    <= '0;
      stub_pat    <= 1'b0;
      attempts[0] <= 0;
      attempts[1] <= 0;
    end else if (bist_start_o) begin
      stub_act <= 1'b1;
      stub_cnt <= '0;
      stub_pat <= bist_pat_o;
      attempts[bist_pat_o] <= attempts[bist_pat_o] + 1;
    end else if (stub_act && stub_cnt < dur_max) begin
      stub_cnt <= stub_cnt + 5'd1;
    end
  end

  assign bist_duration_i = stub_cnt;
  assign bist_success_i  = stub_act && good[stub_pat] &&
                           !(fail_first[stub_pat] && attempts[stub_pat] == 1);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Model: a run is a timeline from its first busy cycle c0; slot k occupies
  // cycles c0+1+20k .. c0+20+20k (start, then sample on the last), done follows the last slot.
  bit       mvalid, m_act, m_pp, m_pj, m_owner, m_pass, m_derr;
  bit [1:0] m_jmask, m_mask, m_res, m_retried;
  int       m_c0;
  int       m_slots[$];

  int first_busy[$], start_cyc[$], done_cyc[$];
  bit start_pat[$];
  bit prev_busy;

  always @(negedge clk) begin
    int rel, slot, off, p;
    bit e_start, e_done, e_patv, e_pat, dok, cp, cj, do_retry;
    e_start = 0; e_done = 0; e_patv = 0; e_pat = 0; slot = 0; off = 0;
    cp = 0; cj = 0; do_retry = 0;
    if (m_act && cyc >= m_c0 + 1) begin
      rel  = cyc - m_c0 - 1;
      slot = rel / 20;
      off  = rel % 20;
      if (slot < m_slots.size()) begin
        e_start = (off == 0);
        e_patv  = 1;
        e_pat   = m_slots[slot][0];
      end else if (slot == m_slots.size() && off == 0) begin
        e_done = 1;
      end
    end

    if (mvalid) begin
      check("busy", busy_o, m_act);
      check("start", bist_start_o, e_start);
      check("done", done_o, e_done);
      if (e_patv) check("pat", bist_pat_o, e_pat);
      check("owner", owner_o, m_owner);
      check("result", result_o, m_res);
      check("pass", pass_o, m_pass);
      check("dur_err", dur_err_o, m_derr);
    end

    if (busy_o === 1'b1 && !prev_busy) first_busy.push_back(cyc);
    prev_busy = (busy_o === 1'b1);
    if (bist_start_o === 1'b1) begin
      start_cyc.push_back(cyc);
      start_pat.push_back(bist_pat_o);
    end
    if (done_o === 1'b1) done_cyc.push_back(cyc);

    if (trst) begin
      mvalid = 1; m_act = 0; m_pp = 0; m_pj = 0; m_owner = 0; m_pass = 0; m_derr = 0;
      m_jmask = 0; m_mask = 0; m_res = 0; m_retried = 0; m_slots.delete();
    end else begin
      if (m_act) begin
        if (abort_i) begin
          m_act = 0; m_res = 0; m_pass = 0;
        end else if (e_patv && off == 19) begin
          p   = m_slots[slot];
          dok = (bist_duration_i == 5'd17);
          if (!dok) m_derr = 1;
`ifdef BIST_SEQ_RETRY_EN
          do_retry = !bist_success_i && dok && !m_retried[p];
`endif
          if (do_retry) begin
            m_retried[p] = 1;
            m_slots.insert(slot + 1, p);
          end else begin
            m_res[p] = bist_success_i && dok;
          end
          if (slot == m_slots.size() - 1) m_pass = ((m_res & m_mask) == m_mask);
        end else if (e_done) begin
          m_act = 0;
        end
      end else if (m_pp || m_pj) begin
        cp = m_pp; cj = !m_pp;
        m_owner = !m_pp;
        m_mask  = m_pp ? 2'b11 : (m_jmask == 2'b00 ? 2'b11 : m_jmask);
        m_act = 1; m_c0 = cyc + 1; m_res = 0; m_pass = 0; m_retried = 0;
        m_slots.delete();
        for (int i = 0; i < 2; i++) if (m_mask[i]) m_slots.push_back(i);
      end
      m_pp = (m_pp && !cp) || por_req_i;
      m_pj = (m_pj && !cj) || jtag_req_i;
      if (jtag_req_i) m_jmask = jtag_mask_i;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs;
    first_busy.delete(); start_cyc.delete(); start_pat.delete(); done_cyc.delete();
  endtask

  task automatic pulse_por;
    por_req_i = 1; tick; por_req_i = 0;
  endtask

  task automatic pulse_jtag(input logic [1:0] m);
    jtag_req_i = 1; jtag_mask_i = m; tick; jtag_req_i = 0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k;
    k = 0;
    while (done_cyc.size() < n && k < budget) begin
      tick;
      k++;
    end
    check("done_timeout", done_cyc.size() >= n, 1);
    tick;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    trst = 1; por_req_i = 0; jtag_req_i = 0; jtag_mask_i = 0; abort_i = 0;
    good = 2'b11; fail_first = 2'b00; dur_max = 5'd17;
    repeat (3) @(posedge clk);
    #1 trst = 0;
    check("rst_busy", busy_o, 0);
    check("rst_start", bist_start_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    check("rst_pass", pass_o, 0);
    check("rst_dur_err", dur_err_o, 0);
    check("rst_owner", owner_o, 0);

    // POR run, healthy engine
    tick; clr_obs;
    pulse_por;
    wait_dones(1, 100);
    check("t1_starts", start_cyc.size(), 2);
    check("t1_start0", start_cyc[0] - first_busy[0], 1);
    check("t1_start1", start_cyc[1] - first_busy[0], 21);
    check("t1_pat0", start_pat[0], 0);
    check("t1_pat1", start_pat[1], 1);
    check("t1_done", done_cyc[0] - first_busy[0], 41);
    check("t1_result", result_o, 2'b11);
    check("t1_pass", pass_o, 1);
    check("t1_owner", owner_o, 0);

    // JTAG mask 10, pattern 1 corrupted
    good = 2'b01; clr_obs;
    pulse_jtag(2'b10);
    wait_dones(1, 100);
    check("t2_starts", start_cyc.size(), 1);
    check("t2_pat", start_pat[0], 1);
    check("t2_done", done_cyc[0] - first_busy[0], 21);
    check("t2_result", result_o, 2'b00);
    check("t2_pass", pass_o, 0);
    check("t2_owner", owner_o, 1);
    good = 2'b11;

    // Simultaneous POR and JTAG (mask 00 means both patterns)
    clr_obs;
    por_req_i = 1; jtag_req_i = 1; jtag_mask_i = 2'b00; tick;
    por_req_i = 0; jtag_req_i = 0;
    wait_dones(2, 200);
    check("t3_dones", done_cyc.size(), 2);
    check("t3_starts", start_cyc.size(), 4);
    check("t3_por_done", done_cyc[0] - first_busy[0], 41);
    check("t3_jtag_gap", first_busy[1] - done_cyc[0], 2);
    check("t3_jtag_done", done_cyc[1] - first_busy[1], 41);
    check("t3_owner", owner_o, 1);
    check("t3_result", result_o, 2'b11);

    // Abort at RUN wait_ctr = 10 with a JTAG request pending
    clr_obs;
    pulse_por;
    k = 0;
    while (busy_o !== 1'b1 && k < 10) begin tick; k++; end
    check("t4_busy_seen", busy_o, 1);
    repeat (5) tick;
    jtag_req_i = 1; jtag_mask_i = 2'b01; tick; jtag_req_i = 0;
    repeat (6) tick;
    abort_i = 1; tick; abort_i = 0;
    check("t4_idle", busy_o, 0);
    check("t4_result", result_o, 2'b00);
    check("t4_no_done", done_cyc.size(), 0);
    tick;
    check("t4_jtag_grant", busy_o, 1);
    check("t4_jtag_owner", owner_o, 1);
    wait_dones(1, 100);
    check("t4_result_after", result_o, 2'b01);
    check("t4_pass_after", pass_o, 1);

    // Short duration at the sample point, then reset
    dur_max = 5'd16; clr_obs;
    pulse_por;
    wait_dones(1, 100);
    check("t5_dur_err", dur_err_o, 1);
    check("t5_result", result_o, 2'b00);
    check("t5_pass", pass_o, 0);
    trst = 1; tick; trst = 0;
    check("t5_rst_dur_err", dur_err_o, 0);
    check("t5_rst_result", result_o, 0);
    check("t5_rst_owner", owner_o, 0);
    check("t5_rst_busy", busy_o, 0);
    dur_max = 5'd17;

`ifdef BIST_SEQ_RETRY_EN
    // Pattern 0 fails once, then passes on its retry
    fail_first = 2'b01; clr_obs;
    pulse_por;
    wait_dones(1, 150);
    check("t6_starts", start_cyc.size(), 3);
    check("t6_pat0", start_pat[0], 0);
    check("t6_pat1", start_pat[1], 0);
    check("t6_pat2", start_pat[2], 1);
    check("t6_done", done_cyc[0] - first_busy[0], 61);
    check("t6_result", result_o, 2'b11);
    check("t6_pass", pass_o, 1);
    fail_first = 2'b00;
`endif

    tick;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
